// File: rtl/cdb_pkg.sv
// Shared CDB definitions: default widths, requester indices and the broadcast payload
// seen by the ROB and reservation stations.
package cdb_pkg;

   localparam int unsigned CDB_TAG_W   = 5;
   localparam int unsigned CDB_DATA_W  = 32;
   localparam int unsigned CDB_NUM_REQ = 4;

   localparam int unsigned REQ_ALU  = 0;
   localparam int unsigned REQ_MUL  = 1;
   localparam int unsigned REQ_LDST = 2;
   localparam int unsigned REQ_BR   = 3;

   typedef struct packed {
      logic [CDB_TAG_W-1:0]  tag;
      logic [CDB_DATA_W-1:0] data;
      logic                  branch;
      logic                  taken;
   } cdb_msg_t;

   // Round-robin successor of idx among n requesters.
   function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
      return (idx + 1) % n;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping modulo N.
module rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned PTR_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] winner,
   output logic             any_grant
);

   logic [PTR_W-1:0] idx;

   always_comb begin
      grant     = '0;
      winner    = '0;
      any_grant = 1'b0;
      idx       = '0;
      for (int unsigned k = 0; k < N; k++) begin
         idx = PTR_W'((32'(ptr) + k) % N);
         if (!any_grant && req[idx]) begin
            any_grant   = 1'b1;
            grant[idx]  = 1'b1;
            winner      = idx;
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: one holding slot per execution unit, round-robin grant,
// registered broadcast toward the ROB and reservation stations.
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned NUM_REQ = CDB_NUM_REQ,
   parameter int unsigned TAG_W   = CDB_TAG_W,
   parameter int unsigned DATA_W  = CDB_DATA_W
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      Flush,
   input  logic [NUM_REQ-1:0]        Req_valid,
   input  logic [NUM_REQ*TAG_W-1:0]  Req_rd_tag,
   input  logic [NUM_REQ*DATA_W-1:0] Req_data,
   input  logic [NUM_REQ-1:0]        Req_branch,
   input  logic [NUM_REQ-1:0]        Req_branch_taken,
   output logic [NUM_REQ-1:0]        Req_ready,
   output logic                      Cdb_valid,
   output logic [TAG_W-1:0]          Cdb_rd_tag,
   output logic [DATA_W-1:0]         Cdb_data,
   output logic                      Cdb_branch,
   output logic                      Cdb_branch_taken
);

   localparam int unsigned PTR_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0] slot_valid;
   logic [NUM_REQ-1:0] slot_branch;
   logic [NUM_REQ-1:0] slot_taken;
   logic [TAG_W-1:0]   slot_tag  [NUM_REQ];
   logic [DATA_W-1:0]  slot_data [NUM_REQ];

   logic [NUM_REQ-1:0] grant;
   logic [NUM_REQ-1:0] take;
   logic [PTR_W-1:0]   rr_ptr;
   logic [PTR_W-1:0]   winner;
   logic               any_grant;

   // Grant depends only on registered slot state, never on the incoming requests.
   rr_arbiter #(
      .N     (NUM_REQ),
      .PTR_W (PTR_W)
   ) u_rr (
      .req       (slot_valid),
      .ptr       (rr_ptr),
      .grant     (grant),
      .winner    (winner),
      .any_grant (any_grant)
   );

   // A slot draining this cycle may be refilled on the same edge.
   assign Req_ready = {NUM_REQ{~Flush}} & (~slot_valid | grant);
   assign take      = Req_valid & Req_ready;

   // Holding slots: capture on transfer, release on grant.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         slot_valid  <= '0;
         slot_branch <= '0;
         slot_taken  <= '0;
         for (int i = 0; i < NUM_REQ; i++) begin
            slot_tag[i]  <= '0;
            slot_data[i] <= '0;
         end
      end else if (Flush) begin
         slot_valid <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (take[i]) begin
               slot_valid[i]  <= 1'b1;
               slot_tag[i]    <= Req_rd_tag[i*TAG_W +: TAG_W];
               slot_data[i]   <= Req_data[i*DATA_W +: DATA_W];
               slot_branch[i] <= Req_branch[i];
               slot_taken[i]  <= Req_branch_taken[i];
            end else if (grant[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
      end
   end

   // Broadcast register and round-robin pointer; idle cycles drive an all-zero bus.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         Cdb_valid        <= 1'b0;
         Cdb_rd_tag       <= '0;
         Cdb_data         <= '0;
         Cdb_branch       <= 1'b0;
         Cdb_branch_taken <= 1'b0;
         rr_ptr           <= '0;
      end else if (Flush || !any_grant) begin
         Cdb_valid        <= 1'b0;
         Cdb_rd_tag       <= '0;
         Cdb_data         <= '0;
         Cdb_branch       <= 1'b0;
         Cdb_branch_taken <= 1'b0;
      end else begin
         Cdb_valid        <= 1'b1;
         Cdb_rd_tag       <= slot_tag[winner];
         Cdb_data         <= slot_data[winner];
         Cdb_branch       <= slot_branch[winner];
         Cdb_branch_taken <= slot_taken[winner];
         rr_ptr           <= PTR_W'(rr_next(32'(winner), NUM_REQ));
      end
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter with hand-computed broadcast sequences.
module tb_cdb_arbiter;

   logic         clock;
   logic         reset;
   logic         Flush;
   logic [3:0]   Req_valid;
   logic [19:0]  Req_rd_tag;
   logic [127:0] Req_data;
   logic [3:0]   Req_branch;
   logic [3:0]   Req_branch_taken;
   logic [3:0]   Req_ready;
   logic         Cdb_valid;
   logic [4:0]   Cdb_rd_tag;
   logic [31:0]  Cdb_data;
   logic         Cdb_branch;
   logic         Cdb_branch_taken;

   int total = 0;
   int bad   = 0;

   cdb_arbiter dut (
      .clock            (clock),
      .reset            (reset),
      .Flush            (Flush),
      .Req_valid        (Req_valid),
      .Req_rd_tag       (Req_rd_tag),
      .Req_data         (Req_data),
      .Req_branch       (Req_branch),
      .Req_branch_taken (Req_branch_taken),
      .Req_ready        (Req_ready),
      .Cdb_valid        (Cdb_valid),
      .Cdb_rd_tag       (Cdb_rd_tag),
      .Cdb_data         (Cdb_data),
      .Cdb_branch       (Cdb_branch),
      .Cdb_branch_taken (Cdb_branch_taken)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Inputs for one cycle and the outputs expected during that same cycle.
   // Requester i drives data + i, so each slot carries distinguishable data.
   typedef struct {
      logic [3:0]  valid;
      logic [19:0] tags;
      logic [31:0] data;
      logic [3:0]  br;
      logic [3:0]  tk;
      logic        fl;
      logic [3:0]  e_ready;
      logic        e_v;
      logic [4:0]  e_tag;
      logic [31:0] e_data;
      logic        e_br;
      logic        e_tk;
   } vec_t;

   function automatic vec_t mk(input logic [3:0] valid, input logic [19:0] tags,
                               input logic [31:0] data, input logic [3:0] br,
                               input logic [3:0] tk, input logic fl,
                               input logic [3:0] e_ready, input logic e_v,
                               input logic [4:0] e_tag, input logic [31:0] e_data,
                               input logic e_br, input logic e_tk);
      vec_t v;
      v.valid = valid; v.tags = tags; v.data = data; v.br = br; v.tk = tk; v.fl = fl;
      v.e_ready = e_ready; v.e_v = e_v; v.e_tag = e_tag; v.e_data = e_data;
      v.e_br = e_br; v.e_tk = e_tk;
      return v;
   endfunction

   function automatic vec_t idle(input logic [3:0] e_ready, input logic e_v,
                                 input logic [4:0] e_tag, input logic [31:0] e_data,
                                 input logic e_br, input logic e_tk);
      return mk(4'b0, 20'b0, 32'b0, 4'b0, 4'b0, 1'b0, e_ready, e_v, e_tag, e_data, e_br, e_tk);
   endfunction

   task automatic drive(input vec_t v);
      Flush            = v.fl;
      Req_valid        = v.valid;
      Req_rd_tag       = v.tags;
      Req_branch       = v.br;
      Req_branch_taken = v.tk;
      for (int i = 0; i < 4; i++) Req_data[i*32 +: 32] = v.data + 32'(i);
   endtask

   task automatic check(input vec_t v, input string name);
      total++;
      if (Req_ready !== v.e_ready) begin
         bad++;
         $display("FAIL %s ready: got=%b want=%b", name, Req_ready, v.e_ready);
      end
      total++;
      if ({Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken} !==
          {v.e_v, v.e_tag, v.e_data, v.e_br, v.e_tk}) begin
         bad++;
         $display("FAIL %s cdb: got v=%b tag=%0d data=%h br=%b tk=%b want v=%b tag=%0d data=%h br=%b tk=%b",
                  name, Cdb_valid, Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken,
                  v.e_v, v.e_tag, v.e_data, v.e_br, v.e_tk);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs sampled on the falling edge.
   task automatic run(input vec_t v, input string name);
      drive(v);
      @(negedge clock);
      check(v, name);
      @(posedge clock);
      #1;
   endtask

   vec_t tbl[$];

   initial begin
      reset = 1'b0;
      drive(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));

      // Reset state, with and without Flush
      @(negedge clock);
      check(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "rst_idle");
      Flush = 1'b1;
      #1;
      check(mk(4'b0, 20'b0, 32'b0, 4'b0, 4'b0, 1'b1, 4'b0000, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "rst_flush");
      Flush = 1'b0;
      #2 reset = 1'b1;
      @(posedge clock);
      #1;

      // All four slots filled at once, rr_ptr=0: broadcasts 1,2,3,4
      tbl.push_back(mk(4'b1111, {5'd4, 5'd3, 5'd2, 5'd1}, 32'h100, 4'b0, 4'b0, 1'b0,
                       4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b0001, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b0011, 1'b1, 5'd1, 32'h100, 1'b0, 1'b0));
      tbl.push_back(idle(4'b0111, 1'b1, 5'd2, 32'h101, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd3, 32'h102, 1'b0, 1'b0));
      // Pair on slots 0 and 3 with rr_ptr back at 0: slot 0 first
      tbl.push_back(mk(4'b1001, {5'd12, 5'd0, 5'd0, 5'd9}, 32'h200, 4'b0, 4'b0, 1'b0,
                       4'b1111, 1'b1, 5'd4, 32'h103, 1'b0, 1'b0));
      tbl.push_back(idle(4'b0111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd9, 32'h200, 1'b0, 1'b0));
      // Single request on slot 2: two-edge latency, one-cycle broadcast
      tbl.push_back(mk(4'b0100, {5'd0, 5'd7, 5'd0, 5'd0}, 32'hDEADBEED, 4'b0, 4'b0, 1'b0,
                       4'b1111, 1'b1, 5'd12, 32'h203, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd7, 32'hDEADBEEF, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      // Requester 1 streams tags 10..19 back to back
      for (int k = 0; k < 10; k++) begin
         tbl.push_back(mk(4'b0010, 20'(k + 10) << 5, 32'h1000 + 32'(16 * k), 4'b0, 4'b0, 1'b0,
                          4'b1111, (k >= 2), (k >= 2) ? 5'(k + 8) : 5'd0,
                          (k >= 2) ? 32'h1001 + 32'(16 * (k - 2)) : 32'h0, 1'b0, 1'b0));
      end
      tbl.push_back(idle(4'b1111, 1'b1, 5'd18, 32'h1081, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd19, 32'h1091, 1'b0, 1'b0));
      // Flush with slots 0,2,3 occupied and a live broadcast; slot 1 request dropped
      tbl.push_back(mk(4'b1101, {5'd23, 5'd22, 5'd0, 5'd20}, 32'h500, 4'b0, 4'b0, 1'b0,
                       4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(mk(4'b0100, {5'd0, 5'd24, 5'd0, 5'd0}, 32'h600, 4'b0, 4'b0, 1'b0,
                       4'b0110, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(mk(4'b0010, {5'd0, 5'd0, 5'd21, 5'd0}, 32'h0, 4'b0, 4'b0, 1'b1,
                       4'b0000, 1'b1, 5'd22, 32'h502, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      // Branch on slot 3 (rr_ptr=3) then plain result on slot 0
      tbl.push_back(mk(4'b1001, {5'd5, 5'd0, 5'd0, 5'd6}, 32'h700, 4'b1000, 4'b1000, 1'b0,
                       4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1110, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd5, 32'h703, 1'b1, 1'b1));
      tbl.push_back(idle(4'b1111, 1'b1, 5'd6, 32'h700, 1'b0, 1'b0));
      tbl.push_back(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      // Load slots 0,1,2 (rr_ptr=1) and refill slot 1 as it is granted
      tbl.push_back(mk(4'b0111, {5'd0, 5'd3, 5'd2, 5'd1}, 32'h800, 4'b0, 4'b0, 1'b0,
                       4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));
      tbl.push_back(mk(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0}, 32'h900, 4'b0, 4'b0, 1'b0,
                       4'b1010, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0));

      foreach (tbl[k]) run(tbl[k], $sformatf("v%0d", k));

      // Mid-operation async reset: three slots full and a broadcast in flight
      drive(idle(4'b1100, 1'b1, 5'd2, 32'h801, 1'b0, 1'b0));
      @(negedge clock);
      check(idle(4'b1100, 1'b1, 5'd2, 32'h801, 1'b0, 1'b0), "pre_rst");
      #1 reset = 1'b0;
      #1;
      check(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "rst_async");
      #1 reset = 1'b1;
      @(posedge clock);
      #1;
      // After release: lowest occupied index wins first, stale slots never return
      run(mk(4'b1010, {5'd14, 5'd0, 5'd13, 5'd0}, 32'hA00, 4'b0, 4'b0, 1'b0,
             4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "post_rst_fill");
      run(idle(4'b0111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "post_rst_wait");
      run(idle(4'b1111, 1'b1, 5'd13, 32'hA01, 1'b0, 1'b0), "post_rst_g1");
      run(idle(4'b1111, 1'b1, 5'd14, 32'hA03, 1'b0, 1'b0), "post_rst_g3");
      run(idle(4'b1111, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0), "post_rst_idle");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Arbitrates the common data bus (CDB) among the execution units of the Tomasulo MIPS core and drives the broadcast that the ROB and reservation stations snoop. Each execution unit hands its completed result (rd tag, data, branch outcome) to a private one-entry holding slot. The arbiter picks one occupied slot per cycle with round-robin priority and broadcasts it from registered outputs. Broadcast outputs connect directly to the ROB `Cdb_*` inputs.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesting execution units (ALU, MUL, LD/ST, BRANCH); 2..8.
- `TAG_W`, 5: width of the ROB rd tag.
- `DATA_W`, 32: result data width.

Ports:
- `clock`  in  1  single clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `Flush`  in  1  synchronous squash (branch mispredict); empties all slots and the CDB register.
- `Req_valid`  in  NUM_REQ  requester i presents a result.
- `Req_rd_tag`  in  NUM_REQ*TAG_W  packed; slice i belongs to requester i.
- `Req_data`  in  NUM_REQ*DATA_W  packed result data.
- `Req_branch`  in  NUM_REQ  result is a branch.
- `Req_branch_taken`  in  NUM_REQ  branch outcome.
- `Req_ready`  out  NUM_REQ  slot i accepts a result this cycle.
- `Cdb_valid`  out  1  broadcast valid.
- `Cdb_rd_tag`  out  TAG_W  broadcast tag.
- `Cdb_data`  out  DATA_W  broadcast data.
- `Cdb_branch`  out  1  broadcast branch flag.
- `Cdb_branch_taken`  out  1  broadcast branch outcome.

## Operation
- Per-requester slot: `slot_valid[i]` plus a captured copy of tag, data, branch and taken.
- Transfer i occurs on an edge where `Req_valid[i] & Req_ready[i]`. The requester holds its fields stable until the transfer.
- `Req_ready[i] = ~Flush & (~slot_valid[i] | grant[i])`. A slot being granted this cycle is refilled on the same edge.
- Grant is combinational from registered `slot_valid` and `rr_ptr` only. There is no path from `Req_*` to grant.
- Round-robin: search starts at `rr_ptr` and proceeds upward modulo NUM_REQ. The first occupied slot wins, and at most one grant is issued per cycle.
- On a grant edge, the winner's fields load into the CDB output register, `Cdb_valid` is set to 1, and `rr_ptr` is set to (winner+1) mod NUM_REQ. The winner's slot is cleared unless it is simultaneously refilled.
- With no occupied slot: `Cdb_valid` is 0, `Cdb_rd_tag`/`Cdb_data`/`Cdb_branch`/`Cdb_branch_taken` are 0, and `rr_ptr` holds.
- Flush: at the next edge, all `slot_valid` go to 0 and `Cdb_valid` plus all Cdb fields go to 0. `rr_ptr` holds. Requests presented in the flush cycle are not accepted.
- A slot is never granted on the edge that fills it. An empty slot never broadcasts.

## Timing
- Reset values: `Cdb_valid=0`, all Cdb fields 0, `slot_valid=0`, `rr_ptr=0`. During reset, `Req_ready` is all 1s unless `Flush=1`.
- Latency: a result accepted at edge t is broadcast in the cycle after edge t+1 at the earliest. Cdb holds it for exactly one cycle.
- Throughput: one broadcast per cycle while any slot is occupied. A single requester can sustain one result per cycle.
- Worst-case wait for an occupied slot: NUM_REQ-1 grants.
- Reset asserted mid-operation drops all queued and broadcasting results asynchronously, with no partial broadcast.

## Structure
- Shared package `cdb_pkg`:
  - `CDB_TAG_W=5`, `CDB_DATA_W=32`, `CDB_NUM_REQ=4`.
  - Requester index constants `REQ_ALU=0`, `REQ_MUL=1`, `REQ_LDST=2`, `REQ_BR=3`.
  - Packed struct `cdb_msg_t` {tag, data, branch, taken}, shared with the ROB and reservation stations.
- Sub-module `rr_arbiter`: inputs are the request vector and `rr_ptr`; outputs are the one-hot grant, the winner index and an any-grant flag. It is purely combinational. The pointer register stays in `cdb_arbiter`.

## Test plan
- Reset with three slots full and `Cdb_valid=1` → outputs 0 immediately. After release, `Req_ready=4'b1111` and the first grant goes to the lowest occupied index.
- Single request: `Req_valid[2]` with tag 7, data 0xDEADBEEF, accepted at edge 1 → after edge 2, `Cdb_valid=1`, tag 7, data 0xDEADBEEF for one cycle, then 0.
- All four slots filled on the same edge with tags 1,2,3,4 → broadcasts 1,2,3,4 on consecutive cycles. A following pair on slots 3 and 0 (`rr_ptr=0`) broadcasts 0 then 3, and the order is checked against `rr_ptr`.
- Requester 1 streams tags 10..19 with valid held high → `Req_ready[1]` stays 1 and 10 consecutive broadcasts 10..19 appear with no bubble.
- Flush with slots 0,2,3 occupied and `Cdb_valid=1` → next cycle `Cdb_valid=0`, slots empty, and the stale tags never appear. The flush-cycle request on slot 1 is dropped (`Req_ready[1]=0`).
- Branch result on slot 3 with `Req_branch=1`, `Req_branch_taken=1` and tag 5 → the broadcast shows branch=1, taken=1, tag 5. A non-branch result from slot 0 in the same window shows branch=0, taken=0.
